// File: rtl/pe_array_v3_pkg.sv
// Shared definitions for the pe_array_v3 matrix-vector PE array:
// FSM state encodings, reduction-mode encodings and a constant clog2 helper.
package pe_array_v3_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_RED  = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    RED_NONE = 2'd0,
    RED_PAIR = 2'd1,
    RED_FULL = 2'd2,
    RED_RSVD = 2'd3
  } red_mode_t;

  // Ceiling log2, usable in constant (parameter) expressions.
  function automatic int pe_clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/pe_array_v3_dot_acc.sv
// One processing element: NUM_MACS unsigned multipliers feeding an adder
// chain, plus an accumulator with first-beat overwrite, enable gating and a
// load port used by the row reduction tree.
// Build option: define PE_ARRAY_SAT_EN to clamp accumulation at 2^ACC_W-1;
// otherwise the accumulator wraps modulo 2^ACC_W.
module pe_array_v3_dot_acc
  import pe_array_v3_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_MACS   = 4,
  parameter int ACC_W      = 24
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           acc_en,
  input  logic                           first,
  input  logic                           en,
  input  logic [NUM_MACS*DATA_WIDTH-1:0] a,
  input  logic [NUM_MACS*DATA_WIDTH-1:0] b,
  input  logic                           ld,
  input  logic [ACC_W-1:0]               ld_val,
  output logic [ACC_W-1:0]               acc
);

  localparam int PROD_W = 2 * DATA_WIDTH;

  logic [ACC_W-1:0] acc_r;
  logic [ACC_W-1:0] dot_s;

  // Accumulate step: wraps by default, clamps when saturation is built in.
  function automatic logic [ACC_W-1:0] add_acc(input logic [ACC_W-1:0] x,
                                               input logic [ACC_W-1:0] y);
`ifdef PE_ARRAY_SAT_EN
    logic [ACC_W:0] sum;
    sum = {1'b0, x} + {1'b0, y};
    if (sum[ACC_W]) begin
      add_acc = {ACC_W{1'b1}};
    end else begin
      add_acc = sum[ACC_W-1:0];
    end
`else
    add_acc = x + y;
`endif
  endfunction

  // Full-precision dot product of this beat's A slice with the broadcast B slice.
  always_comb begin
    logic [PROD_W-1:0] prod;
    dot_s = '0;
    prod  = '0;
    for (int m = 0; m < NUM_MACS; m++) begin
      prod  = {{DATA_WIDTH{1'b0}}, a[m*DATA_WIDTH +: DATA_WIDTH]} *
              {{DATA_WIDTH{1'b0}}, b[m*DATA_WIDTH +: DATA_WIDTH]};
      dot_s = dot_s + ACC_W'(prod);
    end
  end

  // Accumulator: disabled PEs are pinned to 0, first beat overwrites, reduction loads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_r <= '0;
    end else if (acc_en) begin
      if (!en) begin
        acc_r <= '0;
      end else if (first) begin
        acc_r <= dot_s;
      end else begin
        acc_r <= add_acc(acc_r, dot_s);
      end
    end else if (ld) begin
      acc_r <= ld_val;
    end else begin
      acc_r <= acc_r;
    end
  end

  assign acc = acc_r;

endmodule

// File: rtl/pe_array_v3.sv
// Matrix-vector PE array with valid/ready K-tile streaming, an in-row
// reduction tree and a backpressured result port.
// Build option: define PE_ARRAY_SAT_EN to clamp accumulate and reduction
// adds at 2^ACC_W-1; otherwise all sums wrap modulo 2^ACC_W.
module pe_array_v3
  import pe_array_v3_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int NUM_MACS        = 4,
  parameter int NUM_PES_PER_ROW = 4,
  parameter int NUM_ROWS        = 5,
  parameter int ACC_W           = 24
) (
  input  logic                                                 clk,
  input  logic                                                 rst,
  input  logic                                                 in_valid,
  output logic                                                 in_ready,
  input  logic [NUM_ROWS*NUM_PES_PER_ROW*NUM_MACS*DATA_WIDTH-1:0] in_a,
  input  logic [NUM_MACS*DATA_WIDTH-1:0]                       in_b,
  input  logic                                                 in_last,
  input  logic [NUM_ROWS*NUM_PES_PER_ROW-1:0]                  pe_en,
  input  logic [1:0]                                           red_mode,
  output logic                                                 out_valid,
  input  logic                                                 out_ready,
  output logic [NUM_ROWS*NUM_PES_PER_ROW*ACC_W-1:0]            out_data,
  output logic [NUM_ROWS*NUM_PES_PER_ROW-1:0]                  out_mask,
  output logic                                                 busy
);

  localparam int NPR        = NUM_PES_PER_ROW;
  localparam int NUM_PES    = NUM_ROWS * NPR;
  localparam int SLICE_W    = NUM_MACS * DATA_WIDTH;
  localparam int RED_STAGES = pe_clog2(NUM_PES_PER_ROW);
  localparam int STG_W      = 4;

  state_t             state_r;
  state_t             state_next_s;
  logic [STG_W-1:0]   stage_r;
  logic [STG_W-1:0]   n_stages_s;
  red_mode_t          mode_r;
  red_mode_t          mode_in_s;
  red_mode_t          cur_mode_s;
  logic [NUM_PES-1:0] mask_r;
  logic [NUM_PES-1:0] cur_en_s;
  logic [NUM_PES-1:0] mask_calc_s;
  logic [NUM_PES-1:0] out_mask_r;
  logic               in_ready_r;
  logic               out_valid_r;
  logic               busy_r;
  logic               accept_s;
  logic               first_s;
  logic               ld_s;
  logic [ACC_W-1:0]   acc_s [NUM_PES];
  logic [ACC_W-1:0]   red_s [NUM_PES];

  // Reduction add: wraps by default, clamps when saturation is built in.
  function automatic logic [ACC_W-1:0] add_acc(input logic [ACC_W-1:0] x,
                                               input logic [ACC_W-1:0] y);
`ifdef PE_ARRAY_SAT_EN
    logic [ACC_W:0] sum;
    sum = {1'b0, x} + {1'b0, y};
    if (sum[ACC_W]) begin
      add_acc = {ACC_W{1'b1}};
    end else begin
      add_acc = sum[ACC_W-1:0];
    end
`else
    add_acc = x + y;
`endif
  endfunction

  assign accept_s = in_valid && in_ready_r;
  assign first_s  = (state_r == ST_IDLE);
  assign ld_s     = (state_r == ST_RED);

  // Decode the requested reduction mode; the reserved code behaves as "none".
  always_comb begin
    mode_in_s = RED_NONE;
    case (red_mode)
      2'd1:    mode_in_s = RED_PAIR;
      2'd2:    mode_in_s = RED_FULL;
      default: mode_in_s = RED_NONE;
    endcase
  end

  // Mode/mask in force: live inputs on the first beat, captured copies afterwards.
  always_comb begin
    cur_mode_s = mode_r;
    cur_en_s   = mask_r;
    if (first_s) begin
      cur_mode_s = mode_in_s;
      cur_en_s   = pe_en;
    end else begin
      cur_mode_s = mode_r;
      cur_en_s   = mask_r;
    end
  end

  // Number of reduction stages and the result mask implied by the mode.
  always_comb begin
    n_stages_s  = '0;
    mask_calc_s = '0;
    case (cur_mode_s)
      RED_PAIR: begin
        n_stages_s = STG_W'(1);
        for (int r = 0; r < NUM_ROWS; r++) begin
          for (int p = 0; p < NPR; p += 2) begin
            mask_calc_s[r*NPR+p] = cur_en_s[r*NPR+p] | cur_en_s[r*NPR+p+1];
          end
        end
      end
      RED_FULL: begin
        n_stages_s = STG_W'(RED_STAGES);
        for (int r = 0; r < NUM_ROWS; r++) begin
          mask_calc_s[r*NPR] = |cur_en_s[r*NPR +: NPR];
        end
      end
      default: begin
        n_stages_s  = '0;
        mask_calc_s = cur_en_s;
      end
    endcase
  end

  // One reduction stage per cycle: slot j += slot j+2^s for j a multiple of 2^(s+1).
  always_comb begin
    for (int k = 0; k < NUM_PES; k++) begin
      red_s[k] = acc_s[k];
    end
    for (int s = 0; s < RED_STAGES; s++) begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        for (int j = 0; j < NPR; j += (2 << s)) begin
          red_s[r*NPR+j] = (stage_r == STG_W'(s)) ?
                           add_acc(acc_s[r*NPR+j], acc_s[r*NPR+j+(1 << s)]) :
                           red_s[r*NPR+j];
        end
      end
    end
  end

  // Next-state logic for the pass sequencer.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE, ST_ACC: begin
        if (accept_s && in_last) begin
          state_next_s = (n_stages_s == '0) ? ST_OUT : ST_RED;
        end else if (accept_s) begin
          state_next_s = ST_ACC;
        end else begin
          state_next_s = state_r;
        end
      end
      ST_RED: begin
        if (stage_r == (n_stages_s - STG_W'(1))) begin
          state_next_s = ST_OUT;
        end else begin
          state_next_s = ST_RED;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_OUT;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State register and reduction stage counter (counts only while in RED).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      stage_r <= '0;
    end else begin
      state_r <= state_next_s;
      if (state_r == ST_RED) begin
        stage_r <= stage_r + STG_W'(1);
      end else begin
        stage_r <= '0;
      end
    end
  end

  // Registered handshake/status flags, decoded from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      in_ready_r  <= (state_next_s == ST_IDLE) || (state_next_s == ST_ACC);
      out_valid_r <= (state_next_s == ST_OUT);
      busy_r      <= (state_next_s != ST_IDLE);
    end
  end

  // Capture mode and PE enable mask on the first beat of a pass.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_r <= RED_NONE;
      mask_r <= '0;
    end else if (first_s && accept_s) begin
      mode_r <= mode_in_s;
      mask_r <= pe_en;
    end else begin
      mode_r <= mode_r;
      mask_r <= mask_r;
    end
  end

  // Result mask is fixed on entry to OUT and held until the next result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_mask_r <= '0;
    end else if ((state_next_s == ST_OUT) && (state_r != ST_OUT)) begin
      out_mask_r <= mask_calc_s;
    end else begin
      out_mask_r <= out_mask_r;
    end
  end

  for (genvar k = 0; k < NUM_PES; k++) begin : g_pe
    pe_array_v3_dot_acc #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_MACS   (NUM_MACS),
      .ACC_W      (ACC_W)
    ) u_pe (
      .clk    (clk),
      .rst    (rst),
      .acc_en (accept_s),
      .first  (first_s),
      .en     (cur_en_s[k]),
      .a      (in_a[k*SLICE_W +: SLICE_W]),
      .b      (in_b),
      .ld     (ld_s),
      .ld_val (red_s[k]),
      .acc    (acc_s[k])
    );
    assign out_data[k*ACC_W +: ACC_W] = acc_s[k];
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_mask  = out_mask_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_pe_array_v3.sv
// Directed self-checking bench for pe_array_v3 (default 5x4 PEs, 4 MACs,
// 8-bit operands, 24-bit results). Honours PE_ARRAY_SAT_EN for the overflow case.
module tb_pe_array_v3;

  localparam int NP  = 20;
  localparam int AW  = NP * 32;
  localparam int DOW = NP * 24;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [AW-1:0]   in_a;
  logic [31:0]     in_b;
  logic            in_last;
  logic [NP-1:0]   pe_en;
  logic [1:0]      red_mode;
  logic            out_valid;
  logic            out_ready;
  logic [DOW-1:0]  out_data;
  logic [NP-1:0]   out_mask;
  logic            busy;

  int total;
  int bad;

  pe_array_v3 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .pe_en     (pe_en),
    .red_mode  (red_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_mask  (out_mask),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents one beat and holds it until the edge that transfers it.
  task automatic send_beat(input logic [AW-1:0] a, input logic [31:0] b,
                           input logic last, input logic [NP-1:0] en,
                           input logic [1:0] mode);
    int guard;
    guard    = 0;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    pe_en    = en;
    red_mode = mode;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 20) begin
      total++; bad++;
      $display("FAIL beat_accept: in_ready=%b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Counts further clock edges (after the accepting one) until out_valid rises.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b required 0", busy); end
    total++;
    if (out_data !== '0) begin bad++; $display("FAIL reset_out_data: got nonzero required 0"); end
    total++;
    if (out_mask !== '0) begin bad++; $display("FAIL reset_out_mask: got %h required 0", out_mask); end
  endtask

  // Two beats, no reduction: 30 + 174 = 204 in slot 0, valid right after the last beat.
  task automatic test_mode0_two_beat(input string tag);
    logic [AW-1:0] av;
    int lat;
    av = '0;
    av[31:0] = 32'h04030201;
    send_beat(av, 32'h04030201, 1'b0, 20'h00001, 2'd0);
    av[31:0] = 32'h08070605;
    send_beat(av, 32'h08070605, 1'b1, 20'h00001, 2'd0);
    wait_valid(lat);
    total++;
    if (lat != 0) begin bad++; $display("FAIL %s_latency: got %0d extra edges required 0", tag, lat); end
    total++;
    if (out_data[23:0] !== 24'd204) begin bad++; $display("FAIL %s_slot0: got %0d required 204", tag, out_data[23:0]); end
    total++;
    if (out_mask !== 20'h00001) begin bad++; $display("FAIL %s_mask: got %h required 00001", tag, out_mask); end
    release_out();
  endtask

  // Full-row reduction of four dot products of 4 each -> 16 at slot 0 after two stages.
  task automatic test_full_row();
    logic [AW-1:0] av;
    int lat;
    av = '0;
    for (int k = 0; k < 4; k++) av[k*32 +: 32] = 32'h01010101;
    send_beat(av, 32'h01010101, 1'b1, 20'h0000F, 2'd2);
    wait_valid(lat);
    total++;
    if (lat != 2) begin bad++; $display("FAIL full_latency: got %0d extra edges required 2", lat); end
    total++;
    if (out_data[23:0] !== 24'd16) begin bad++; $display("FAIL full_slot0: got %0d required 16", out_data[23:0]); end
    total++;
    if (out_data[2*24 +: 24] !== 24'd8) begin bad++; $display("FAIL full_slot2_partial: got %0d required 8", out_data[2*24 +: 24]); end
    total++;
    if (out_mask !== 20'h00001) begin bad++; $display("FAIL full_mask: got %h required 00001", out_mask); end
    release_out();
  endtask

  // 65 beats of 4*255*255 = 260100 each: 16906500 overflows 24 bits.
  task automatic test_overflow();
    logic [AW-1:0] av;
    logic [23:0] exp_v;
    int lat;
`ifdef PE_ARRAY_SAT_EN
    exp_v = 24'd16777215;
`else
    exp_v = 24'd129284;
`endif
    av = '0;
    av[31:0] = 32'hFFFFFFFF;
    for (int i = 0; i < 65; i++) begin
      send_beat(av, 32'hFFFFFFFF, (i == 64), 20'h00001, 2'd0);
    end
    wait_valid(lat);
    total++;
    if (out_data[23:0] !== exp_v) begin bad++; $display("FAIL overflow_slot0: got %0d required %0d", out_data[23:0], exp_v); end
    release_out();
  endtask

  // Result held under backpressure for 5 cycles, with in_valid ignored meanwhile.
  task automatic test_backpressure();
    logic [AW-1:0] av;
    int lat;
    av = '0;
    av[31:0] = 32'h02020202;
    send_beat(av, 32'h02020202, 1'b1, 20'h00001, 2'd0);
    wait_valid(lat);
    in_a     = {AW{1'b1}};
    in_b     = 32'hFFFFFFFF;
    in_last  = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++;
      if (out_data[23:0] !== 24'd16) begin bad++; $display("FAIL stall_data[%0d]: got %0d required 16", i, out_data[23:0]); end
      total++;
      if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready[%0d]: got %b required 0", i, in_ready); end
      total++;
      if (busy !== 1'b1 || out_valid !== 1'b1) begin bad++; $display("FAIL stall_busy_valid[%0d]: got %b%b required 11", i, busy, out_valid); end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    release_out();
    total++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL stall_release: busy/in_ready/out_valid=%b%b%b required 010", busy, in_ready, out_valid);
    end
  endtask

  // Pairwise mode with row1 PE2 disabled: row1 slot2 = 0+4, slot0 = 8.
  task automatic test_pair_masked();
    logic [AW-1:0] av;
    int lat;
    for (int k = 0; k < NP; k++) av[k*32 +: 32] = 32'h01010101;
    send_beat(av, 32'h01010101, 1'b1, 20'hFFFBF, 2'd1);
    wait_valid(lat);
    total++;
    if (lat != 1) begin bad++; $display("FAIL pair_latency: got %0d extra edges required 1", lat); end
    total++;
    if (out_data[6*24 +: 24] !== 24'd4) begin bad++; $display("FAIL pair_row1_slot2: got %0d required 4", out_data[6*24 +: 24]); end
    total++;
    if (out_data[4*24 +: 24] !== 24'd8) begin bad++; $display("FAIL pair_row1_slot0: got %0d required 8", out_data[4*24 +: 24]); end
    total++;
    if (out_mask !== 20'h55555) begin bad++; $display("FAIL pair_mask: got %h required 55555", out_mask); end
    release_out();
  endtask

  // Reset during RED discards the pass; the following pass is unaffected.
  task automatic test_reset_mid_pass();
    logic [AW-1:0] av;
    av = '0;
    for (int k = 0; k < 4; k++) av[k*32 +: 32] = 32'h01010101;
    send_beat(av, 32'h01010101, 1'b1, 20'h0000F, 2'd2);
    rst = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL midrst_flags: out_valid/in_ready/busy=%b%b%b required 010", out_valid, in_ready, busy);
    end
    total++;
    if (out_data !== '0) begin bad++; $display("FAIL midrst_acc: slot0=%0d required 0", out_data[23:0]); end
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    test_mode0_two_beat("after_rst");
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_last   = 1'b0;
    pe_en     = '0;
    red_mode  = 2'd0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_mode0_two_beat("mode0");
    test_full_row();
    test_overflow();
    test_backpressure();
    test_pair_masked();
    test_reset_mid_pass();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
